// File: rtl/cdc_word_tx.sv
// rtl/cdc_word_tx.sv - source end of a four-phase req/ack word transfer
module cdc_word_tx #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             req_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ack_i,
  output logic             busy,
  output logic             proto_err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RELEASE
  } state_t;

  state_t            state, state_nx;
  logic [STAGES-1:0] ack_q;
  logic              ack_sync;
  logic              ack_sync_d;
  logic              init_done;
  logic              req_nx;
  logic [WIDTH-1:0]  data_nx;
  logic              err_nx;

  assign ack_sync = ack_q[STAGES-1];
  assign s_ready  = (state == IDLE) & ~ack_sync & init_done;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ack_q      <= '0;
      ack_sync_d <= 1'b0;
      init_done  <= 1'b0;
      req_o      <= 1'b0;
      data_o     <= '0;
      proto_err  <= 1'b0;
    end else begin
      ack_q      <= {ack_q[STAGES-2:0], ack_i};
      ack_sync_d <= ack_sync;
      init_done  <= 1'b1;
      state      <= state_nx;
      req_o      <= req_nx;
      data_o     <= data_nx;
      proto_err  <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    req_nx   = req_o;
    data_nx  = data_o;
    err_nx   = proto_err;
    case (state)
      IDLE: begin
        // an ack rising with no request outstanding is a destination-side fault
        if (init_done && ack_sync && !ack_sync_d) begin
          err_nx = 1'b1;
        end
        if (s_valid && s_ready) begin
          data_nx  = s_data;
          req_nx   = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        if (ack_sync) begin
          req_nx   = 1'b0;
          state_nx = RELEASE;
        end
      end
      RELEASE: begin
        if (!ack_sync) begin
          state_nx = IDLE;
        end
      end
      default: begin
        req_nx   = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cdc_word_tx.sv
// tb/tb_cdc_word_tx.sv - self-checking bench for cdc_word_tx
module tb_cdc_word_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       man_ack = 1'b0;
  logic       resp_ack = 1'b0;
  logic       auto_resp = 1'b0;
  logic       ack;

  logic       rdy2, req2, busy2, err2;
  logic [7:0] dat2;
  logic       rdy3, req3, busy3, err3;
  logic [7:0] dat3;

  logic       s_ready_m, req_m, busy_m, err_m;
  logic [7:0] data_m;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] rcv[$];
  logic [7:0] exp_q[$];
  logic       stream_mode = 1'b0;
  int         rdy_pulses = 0;
  logic       prev_req = 1'b0;
  logic [7:0] prev_data = 8'h00;

  typedef struct {
    logic [7:0] data;
    int         up;
    int         dn;
    int         lat;
  } vec_t;

  vec_t tbl[4];

  always #5 clk = ~clk;

  assign ack = auto_resp ? resp_ack : man_ack;

  cdc_word_tx #(.WIDTH(8), .STAGES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid & ~sel), .s_ready(rdy2),
    .s_data(s_data), .req_o(req2), .data_o(dat2), .ack_i(ack & ~sel),
    .busy(busy2), .proto_err(err2)
  );

  cdc_word_tx #(.WIDTH(8), .STAGES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid & sel), .s_ready(rdy3),
    .s_data(s_data), .req_o(req3), .data_o(dat3), .ack_i(ack & sel),
    .busy(busy3), .proto_err(err3)
  );

  assign s_ready_m = sel ? rdy3  : rdy2;
  assign req_m     = sel ? req3  : req2;
  assign data_m    = sel ? dat3  : dat2;
  assign busy_m    = sel ? busy3 : busy2;
  assign err_m     = sel ? err3  : err2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] d, input int up, input int dn, input int lat, input string nm);
    int n;
    n = 0;
    while (!s_ready_m && n < 50) begin tick(); n++; end
    chk(32'(s_ready_m), 1, {nm, " ready_before_accept"});
    s_data  = d;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    s_data  = 8'hFF;
    chk(32'(req_m), 1, {nm, " req_one_cycle_after_accept"});
    chk(32'(data_m), 32'(d), {nm, " data_o"});
    chk(32'(s_ready_m), 0, {nm, " ready_low_when_busy"});
    repeat (up) tick();
    man_ack = 1'b1;
    n = 0;
    do begin tick(); n++; end while (req_m && n < 20);
    chk(n, lat, {nm, " ack_rise_to_req_fall"});
    repeat (dn) tick();
    man_ack = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!s_ready_m && n < 20);
    chk(n, lat, {nm, " ack_fall_to_ready"});
    chk(32'(data_m), 32'(d), {nm, " data_o_held_in_idle"});
  endtask

  // data_o must never move while the request is up; stream phase must never show 0xFF
  always @(negedge clk) begin
    if (rst_n && prev_req && req_m) begin
      checks++;
      if (data_m !== prev_data) begin
        errors++;
        $display("FAIL data_stable: got %0h expected %0h", data_m, prev_data);
      end
    end
    if (stream_mode) begin
      if (s_ready_m) rdy_pulses++;
      if (req_m && data_m === 8'hFF) begin
        errors++;
        $display("FAIL stream_no_ff: got %0h expected not ff", data_m);
      end
    end
    prev_req  = req_m;
    prev_data = data_m;
  end

  // destination model: captures the word at each new request, then runs the four phases
  initial begin
    int n;
    forever begin
      @(negedge clk);
      if (auto_resp && req_m && !resp_ack) begin
        rcv.push_back(data_m);
        repeat ($urandom_range(0, 4)) @(negedge clk);
        resp_ack = 1'b1;
        n = 0;
        while (req_m && n < 100) begin @(negedge clk); n++; end
        if (req_m) begin
          checks++;
          errors++;
          $display("FAIL resp_req_fall: got req 1 expected 0");
        end
        repeat ($urandom_range(0, 4)) @(negedge clk);
        resp_ack = 1'b0;
      end
    end
  end

  initial begin
    int n;
    tbl[0] = '{data: 8'hA5, up: 3, dn: 3, lat: 3};
    tbl[1] = '{data: 8'h00, up: 0, dn: 0, lat: 3};
    tbl[2] = '{data: 8'hFF, up: 5, dn: 1, lat: 3};
    tbl[3] = '{data: 8'h81, up: 1, dn: 6, lat: 3};

    // reset with upstream pushing
    s_valid = 1'b1;
    s_data  = 8'h77;
    repeat (3) tick();
    chk(32'(req_m), 0, "rst req_o");
    chk(32'(data_m), 0, "rst data_o");
    chk(32'(s_ready_m), 0, "rst s_ready");
    chk(32'(busy_m), 0, "rst busy");
    chk(32'(err_m), 0, "rst proto_err");
    #2 rst_n = 1'b1;
    #1 chk(32'(s_ready_m), 0, "ready_before_first_edge");
    tick();
    chk(32'(s_ready_m), 1, "ready_one_edge_after_release");
    s_valid = 1'b0;
    chk(32'(req_m), 0, "no_accept_before_init");

    for (int i = 0; i < 4; i++) begin
      xfer(tbl[i].data, tbl[i].up, tbl[i].dn, tbl[i].lat, $sformatf("vec%0d", i));
    end

    // streaming with s_valid held high and junk data while busy
    auto_resp = 1'b1;
    rcv.delete();
    rdy_pulses = 0;
    stream_mode = 1'b1;
    for (int w = 1; w <= 3; w++) begin
      n = 0;
      while (!s_ready_m && n < 200) begin tick(); n++; end
      s_data  = 8'(w);
      s_valid = 1'b1;
      tick();
      s_data = 8'hFF;
    end
    s_valid = 1'b0;
    stream_mode = 1'b0;
    n = 0;
    while ((rcv.size() < 3 || !s_ready_m) && n < 300) begin tick(); n++; end
    chk(rcv.size(), 3, "stream count");
    for (int i = 0; i < 3 && i < rcv.size(); i++) chk(32'(rcv[i]), i + 1, $sformatf("stream word%0d", i));
    chk(rdy_pulses, 3, "stream ready pulses");

    // randomized traffic against an in-order scoreboard
    rcv.delete();
    exp_q.delete();
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      s_data  = 8'($urandom);
      s_valid = 1'b1;
      n = 0;
      while (!s_ready_m && n < 200) begin tick(); n++; end
      exp_q.push_back(s_data);
      tick();
      s_valid = 1'b0;
      s_data  = 8'($urandom);
    end
    n = 0;
    while ((rcv.size() < 20 || !s_ready_m) && n < 1000) begin tick(); n++; end
    chk(rcv.size(), 20, "rand count");
    for (int i = 0; i < 20 && i < rcv.size(); i++) chk(32'(rcv[i]), 32'(exp_q[i]), $sformatf("rand word%0d", i));
    auto_resp = 1'b0;
    tick();

    // spurious ack while idle
    chk(32'(err_m), 0, "err_clear_before_spurious");
    man_ack = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk(32'(req_m), 0, $sformatf("spur req cyc%0d", i));
      if (i >= 2) chk(32'(s_ready_m), 0, $sformatf("spur ready cyc%0d", i));
      if (i >= 3) chk(32'(err_m), 1, $sformatf("spur err cyc%0d", i));
    end
    man_ack = 1'b0;
    repeat (4) tick();
    chk(32'(err_m), 1, "spur err sticky");
    chk(32'(req_m), 0, "spur req after");
    chk(32'(busy_m), 0, "spur stays idle");
    chk(32'(s_ready_m), 1, "spur ready returns");

    // reset in the middle of a request
    s_data  = 8'h99;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    chk(32'(req_m), 1, "midrst req up");
    tick();
    #3 rst_n = 1'b0;
    #1;
    chk(32'(req_m), 0, "midrst req async");
    chk(32'(data_m), 0, "midrst data async");
    chk(32'(busy_m), 0, "midrst busy");
    chk(32'(err_m), 0, "midrst err cleared");
    tick();
    #2 rst_n = 1'b1;
    tick();
    xfer(8'h3C, 3, 3, 3, "after_rst");

    // deeper synchronizer
    sel = 1'b1;
    #1;
    xfer(8'h5A, 3, 3, 4, "stages3");
    chk(32'(err_m), 0, "stages3 no err");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
